// File: rtl/lcd_nibble_reader_pkg.sv
// Shared LCD timing table and reader FSM encodings, common to the HD44780 writer and reader.
package lcd_nibble_reader_pkg;

    typedef enum logic [2:0] {
        LCDR_IDLE  = 3'd0,
        LCDR_SETUP = 3'd1,
        LCDR_E_HI1 = 3'd2,
        LCDR_GAP   = 3'd3,
        LCDR_E_HI2 = 3'd4,
        LCDR_HOLD  = 3'd5,
        LCDR_DONE  = 3'd6
    } lcdr_state_e;

    // Cycle counts at 50 MHz
    localparam int LCD_SETUP_CYCLES  = 2;
    localparam int LCD_E_HIGH_CYCLES = 12;
    localparam int LCD_GAP_CYCLES    = 38;
    localparam int LCD_HOLD_CYCLES   = 1;

    function automatic int lcd_max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/lcd_nibble_reader_if.sv
// Datapath request/result signals plus the LCD pin group driven by the nibble reader.
interface lcd_nibble_reader_if;
    logic       iReadRequest;
    logic       iRegSelect;
    logic [3:0] iLCD_Data;
    logic       oLCD_Enabled;
    logic       oLCD_RS;
    logic       oLCD_RW;
    logic       oBusy;
    logic [7:0] oData;
    logic       oDataValid;
    logic       oBusyFlag;

    modport slave (
        input  iReadRequest, iRegSelect, iLCD_Data,
        output oLCD_Enabled, oLCD_RS, oLCD_RW, oBusy, oData, oDataValid, oBusyFlag
    );

    modport master (
        output iReadRequest, iRegSelect, iLCD_Data,
        input  oLCD_Enabled, oLCD_RS, oLCD_RW, oBusy, oData, oDataValid, oBusyFlag
    );
endinterface

// File: rtl/lcd_cycle_timer.sv
// Loadable down-counter that parks at zero; oExpired marks the last cycle of a timed phase.
module lcd_cycle_timer #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          iLoad,
    input  logic [CW-1:0] iLoadValue,
    output logic          oExpired
);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (iLoad)
            cnt_d = iLoadValue;
        else if (cnt_q != '0)
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign oExpired = (cnt_q == '0);

endmodule

// File: rtl/lcd_nibble_reader.sv
// HD44780 4-bit read: two E strobes with RW=1, high nibble first, byte published in DONE.
module lcd_nibble_reader
    import lcd_nibble_reader_pkg::*;
#(
    parameter int SETUP_CYCLES  = LCD_SETUP_CYCLES,
    parameter int E_HIGH_CYCLES = LCD_E_HIGH_CYCLES,
    parameter int GAP_CYCLES    = LCD_GAP_CYCLES,
    parameter int HOLD_CYCLES   = LCD_HOLD_CYCLES
) (
    input logic                 clk,
    input logic                 rst,
    lcd_nibble_reader_if.slave  bus
);

    localparam int CW = $clog2(lcd_max4(SETUP_CYCLES, E_HIGH_CYCLES, GAP_CYCLES, HOLD_CYCLES)) + 1;

    if (SETUP_CYCLES < 1 || E_HIGH_CYCLES < 1 || GAP_CYCLES < 1 || HOLD_CYCLES < 0) begin : g_bad_param
        $error("lcd_nibble_reader: only HOLD_CYCLES may be zero");
    end

    lcdr_state_e   state_q;
    logic          e_q, rs_q, rw_q, busy_q, valid_q, bf_q;
    logic [7:0]    data_q;
    logic [3:0]    hi_q, lo_q;
    logic          ld_d;
    logic [CW-1:0] ld_val_d;
    logic          expired;

    lcd_cycle_timer #(.CW(CW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .iLoad      (ld_d),
        .iLoadValue (ld_val_d),
        .oExpired   (expired)
    );

    // Timer reload accompanies every timed-state entry; counts N-1 down to 0
    always_comb begin
        ld_d     = 1'b0;
        ld_val_d = '0;
        case (state_q)
            LCDR_IDLE:  if (bus.iReadRequest) begin ld_d = 1'b1; ld_val_d = CW'(SETUP_CYCLES - 1);  end
            LCDR_SETUP: if (expired)          begin ld_d = 1'b1; ld_val_d = CW'(E_HIGH_CYCLES - 1); end
            LCDR_E_HI1: if (expired)          begin ld_d = 1'b1; ld_val_d = CW'(GAP_CYCLES - 1);    end
            LCDR_GAP:   if (expired)          begin ld_d = 1'b1; ld_val_d = CW'(E_HIGH_CYCLES - 1); end
            LCDR_E_HI2: if (expired && HOLD_CYCLES > 0) begin
                ld_d     = 1'b1;
                ld_val_d = CW'(HOLD_CYCLES - 1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= LCDR_IDLE;
            e_q     <= 1'b0;
            rs_q    <= 1'b0;
            rw_q    <= 1'b0;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
            bf_q    <= 1'b0;
            data_q  <= 8'h00;
            hi_q    <= 4'h0;
            lo_q    <= 4'h0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                LCDR_IDLE: if (bus.iReadRequest) begin
                    state_q <= LCDR_SETUP;
                    rs_q    <= bus.iRegSelect;
                    rw_q    <= 1'b1;
                    busy_q  <= 1'b1;
                end
                LCDR_SETUP: if (expired) begin
                    state_q <= LCDR_E_HI1;
                    e_q     <= 1'b1;
                end
                LCDR_E_HI1: if (expired) begin
                    state_q <= LCDR_GAP;
                    e_q     <= 1'b0;
                    hi_q    <= bus.iLCD_Data;
                end
                LCDR_GAP: if (expired) begin
                    state_q <= LCDR_E_HI2;
                    e_q     <= 1'b1;
                end
                LCDR_E_HI2: if (expired) begin
                    e_q  <= 1'b0;
                    lo_q <= bus.iLCD_Data;
                    if (HOLD_CYCLES > 0) begin
                        state_q <= LCDR_HOLD;
                    end else begin
                        state_q <= LCDR_DONE;
                        rw_q    <= 1'b0;
                        valid_q <= 1'b1;
                        data_q  <= {hi_q, bus.iLCD_Data};
                        if (!rs_q) bf_q <= hi_q[3];
                    end
                end
                LCDR_HOLD: if (expired) begin
                    state_q <= LCDR_DONE;
                    rw_q    <= 1'b0;
                    valid_q <= 1'b1;
                    data_q  <= {hi_q, lo_q};
                    if (!rs_q) bf_q <= hi_q[3];
                end
                LCDR_DONE: begin
                    state_q <= LCDR_IDLE;
                    busy_q  <= 1'b0;
                    rs_q    <= 1'b0;
                end
                default: state_q <= LCDR_IDLE;
            endcase
        end
    end

    assign bus.oLCD_Enabled = e_q;
    assign bus.oLCD_RS      = rs_q;
    assign bus.oLCD_RW      = rw_q;
    assign bus.oBusy        = busy_q;
    assign bus.oData        = data_q;
    assign bus.oDataValid   = valid_q;
    assign bus.oBusyFlag    = bf_q;

endmodule

// File: tb/tb_lcd_nibble_reader.sv
// Directed bench for lcd_nibble_reader: vector table of single reads plus multi-cycle corner sequences.
module tb_lcd_nibble_reader;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lcd_nibble_reader_if bus();

    lcd_nibble_reader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Panel model: valid nibble only while E is high, inverted junk otherwise
    logic [7:0] pbytes [0:127];
    logic [7:0] ecnt;
    logic [7:0] cur_b;
    logic [3:0] cur_nib;

    always @(negedge bus.oLCD_Enabled or posedge rst) begin
        if (rst) ecnt <= 8'd0;
        else     ecnt <= ecnt + 8'd1;
    end

    assign cur_b         = pbytes[ecnt[7:1]];
    assign cur_nib       = ecnt[0] ? cur_b[3:0] : cur_b[7:4];
    assign bus.iLCD_Data = bus.oLCD_Enabled ? cur_nib : ~cur_nib;

    // Protocol watcher: E only during a read, RS/RW steady across every E-high stretch
    int   viol = 0;
    logic pe = 1'b0, prs = 1'b0, prw = 1'b0;
    always @(negedge clk) begin
        if (bus.oLCD_Enabled && !bus.oLCD_RW) begin
            viol <= viol + 1;
            $display("watch: E high with RW low at %0t", $time);
        end
        if (pe && bus.oLCD_Enabled && (bus.oLCD_RS !== prs || bus.oLCD_RW !== prw)) begin
            viol <= viol + 1;
            $display("watch: RS/RW moved while E high at %0t", $time);
        end
        pe  <= bus.oLCD_Enabled;
        prs <= bus.oLCD_RS;
        prw <= bus.oLCD_RW;
    end

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // One pulsed read; optionally re-pulses the request (with RS flipped) at cycle inj
    task automatic do_read(input logic rsv, input logic [7:0] b, input int inj,
                           output int lat, output int ecyc, output int rwcyc, output int rsbad,
                           output int nvalid, output int e1, output int elast, output logic [7:0] dat);
        logic prev_e;
        lat = -1; ecyc = 0; rwcyc = 0; rsbad = 0; nvalid = 0; e1 = -1; elast = -1;
        dat = 8'h00; prev_e = 1'b0;
        pbytes[ecnt[7:1]] = b;
        @(negedge clk);
        bus.iRegSelect   = rsv;
        bus.iReadRequest = 1'b1;
        @(negedge clk);
        bus.iReadRequest = 1'b0;
        bus.iRegSelect   = ~rsv;
        for (int n = 1; n <= 150; n++) begin
            if (n > 1) @(negedge clk);
            if (n == inj) begin
                bus.iReadRequest = 1'b1;
                bus.iRegSelect   = ~rsv;
            end
            if (n == inj + 1) bus.iReadRequest = 1'b0;
            if (bus.oLCD_Enabled) begin
                ecyc++;
                if (!prev_e) begin
                    if (e1 < 0) e1 = n;
                    elast = n;
                end
            end
            prev_e = bus.oLCD_Enabled;
            if (bus.oLCD_RW) rwcyc++;
            if (bus.oBusy && bus.oLCD_RS !== rsv) rsbad++;
            if (bus.oDataValid) begin
                nvalid++;
                if (lat < 0) lat = n;
                dat = bus.oData;
            end
        end
    endtask

    typedef struct {
        logic       rs;
        logic [7:0] b;
        logic [7:0] exp_d;
        logic       exp_bf;
    } vec_t;

    vec_t vecs [0:4];

    initial begin
        int lat, ecyc, rwcyc, rsbad, nvalid, e1, elast;
        logic [7:0] dat;
        logic e_seen, busy_seen;
        int nv;
        int vt [0:3];
        logic [7:0] vd [0:3];
        logic [6:0] base;

        vecs[0] = '{rs: 1'b0, b: 8'hA3, exp_d: 8'hA3, exp_bf: 1'b1};
        vecs[1] = '{rs: 1'b1, b: 8'h41, exp_d: 8'h41, exp_bf: 1'b1};
        vecs[2] = '{rs: 1'b0, b: 8'h7F, exp_d: 8'h7F, exp_bf: 1'b0};
        vecs[3] = '{rs: 1'b1, b: 8'h80, exp_d: 8'h80, exp_bf: 1'b0};
        vecs[4] = '{rs: 1'b0, b: 8'hF0, exp_d: 8'hF0, exp_bf: 1'b1};

        for (int i = 0; i < 128; i++) pbytes[i] = 8'h00;
        bus.iReadRequest = 1'b0;
        bus.iRegSelect   = 1'b0;

        #2 rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        chk("rst_data",  {24'd0, bus.oData}, 32'h00);
        chk("rst_valid", {31'd0, bus.oDataValid}, 32'd0);
        chk("rst_E",     {31'd0, bus.oLCD_Enabled}, 32'd0);
        chk("rst_RS",    {31'd0, bus.oLCD_RS}, 32'd0);
        chk("rst_RW",    {31'd0, bus.oLCD_RW}, 32'd0);
        chk("rst_busy",  {31'd0, bus.oBusy}, 32'd0);
        chk("rst_bf",    {31'd0, bus.oBusyFlag}, 32'd0);

        e_seen = 1'b0; busy_seen = 1'b0;
        for (int n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.oLCD_Enabled) e_seen = 1'b1;
            if (bus.oBusy || bus.oLCD_RW || bus.oDataValid) busy_seen = 1'b1;
        end
        chk("idle_E_rise", {31'd0, e_seen}, 32'd0);
        chk("idle_busy",   {31'd0, busy_seen}, 32'd0);

        for (int v = 0; v < 5; v++) begin
            do_read(vecs[v].rs, vecs[v].b, 0, lat, ecyc, rwcyc, rsbad, nvalid, e1, elast, dat);
            chk($sformatf("v%0d_latency", v), lat, 32'd66);
            chk($sformatf("v%0d_data", v), {24'd0, dat}, {24'd0, vecs[v].exp_d});
            chk($sformatf("v%0d_bf", v), {31'd0, bus.oBusyFlag}, {31'd0, vecs[v].exp_bf});
            chk($sformatf("v%0d_valid_pulses", v), nvalid, 32'd1);
            chk($sformatf("v%0d_E_cycles", v), ecyc, 32'd24);
            chk($sformatf("v%0d_RW_cycles", v), rwcyc, 32'd65);
            chk($sformatf("v%0d_RS_changes", v), rsbad, 32'd0);
            chk($sformatf("v%0d_E1_rise", v), e1, 32'd3);
            chk($sformatf("v%0d_E2_rise", v), elast, 32'd53);
        end

        // Request re-pulsed during GAP with RS flipped: ignored
        do_read(1'b0, 8'h2C, 30, lat, ecyc, rwcyc, rsbad, nvalid, e1, elast, dat);
        chk("ign_valid_pulses", nvalid, 32'd1);
        chk("ign_data", {24'd0, dat}, 32'h2C);
        chk("ign_RS_changes", rsbad, 32'd0);
        chk("ign_E_cycles", ecyc, 32'd24);
        chk("ign_bf", {31'd0, bus.oBusyFlag}, 32'd0);

        // Reset between clock edges during the second E strobe
        pbytes[ecnt[7:1]] = 8'h5A;
        @(negedge clk);
        bus.iRegSelect = 1'b0; bus.iReadRequest = 1'b1;
        @(negedge clk);
        bus.iReadRequest = 1'b0;
        repeat (57) @(negedge clk);
        chk("mid_E_before_rst", {31'd0, bus.oLCD_Enabled}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_E",    {31'd0, bus.oLCD_Enabled}, 32'd0);
        chk("mid_rst_RW",   {31'd0, bus.oLCD_RW}, 32'd0);
        chk("mid_rst_busy", {31'd0, bus.oBusy}, 32'd0);
        chk("mid_rst_data", {24'd0, bus.oData}, 32'h00);
        chk("mid_rst_bf",   {31'd0, bus.oBusyFlag}, 32'd0);
        @(negedge clk);
        chk("mid_rst_data_hold", {24'd0, bus.oData}, 32'h00);
        rst = 1'b0;
        do_read(1'b1, 8'h6D, 0, lat, ecyc, rwcyc, rsbad, nvalid, e1, elast, dat);
        chk("post_rst_latency", lat, 32'd66);
        chk("post_rst_data", {24'd0, dat}, 32'h6D);
        chk("post_rst_bf", {31'd0, bus.oBusyFlag}, 32'd0);

        // Request held high: three back-to-back reads
        base = ecnt[7:1];
        pbytes[base]        = 8'hC5;
        pbytes[base + 7'd1] = 8'h9E;
        pbytes[base + 7'd2] = 8'h01;
        nv = 0;
        for (int i = 0; i < 4; i++) begin vt[i] = 0; vd[i] = 8'h00; end
        @(negedge clk);
        bus.iRegSelect = 1'b0; bus.iReadRequest = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clk);
            if (bus.oDataValid) begin
                if (nv < 4) begin vt[nv] = n; vd[nv] = bus.oData; end
                nv++;
                if (nv == 3) bus.iReadRequest = 1'b0;
            end
        end
        chk("b2b_count", nv, 32'd3);
        chk("b2b_first", vt[0], 32'd66);
        chk("b2b_gap1", vt[1] - vt[0], 32'd67);
        chk("b2b_gap2", vt[2] - vt[1], 32'd67);
        chk("b2b_d0", {24'd0, vd[0]}, 32'hC5);
        chk("b2b_d1", {24'd0, vd[1]}, 32'h9E);
        chk("b2b_d2", {24'd0, vd[2]}, 32'h01);
        chk("b2b_bf", {31'd0, bus.oBusyFlag}, 32'd0);
        chk("b2b_idle_after", {31'd0, bus.oBusy}, 32'd0);

        @(negedge clk);
        chk("protocol_watch", viol, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
